ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader_if.sv | 12 +
 rtl/ccff_loader.sv | 186 ++++++++++++++++++
 tb/tb_ccff_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_loader_if.sv
// Bitstream word stream carrying configuration words into the chain loader.
// The master side supplies words and the loader (slave) accepts them with a ready/valid handshake.
interface ccff_loader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_loader.sv
// Configuration flip-flop chain loader: serialises bitstream words, MSB first,
// into a CHAIN_LEN-long shift chain.
// Optional feature macro CCFF_READBACK_EN adds a loopback verify pass with CRC-8 compare.
module ccff_loader #(
   parameter int CHAIN_LEN = 52,
   parameter int WORD_W    = 8
) (
   input  logic         prog_clk,
   input  logic         pReset,
   input  logic         start,
   ccff_loader_if.slave cfg,
   output logic         ccff_head,
   output logic         config_enable,
   input  logic         ccff_tail,
   output logic         busy,
   output logic         done
`ifdef CCFF_READBACK_EN
   ,
   output logic         crc_err
`endif
);

   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int REM       = CHAIN_LEN % WORD_W;
   localparam int LAST_BITS = (REM == 0) ? WORD_W : REM;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int WCNT_W    = $clog2(NWORDS + 1);
   localparam int BCNT_W    = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
`ifdef CCFF_READBACK_EN
      S_VERIFY = 2'd2,
`endif
      S_DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;
   logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [BCNT_W-1:0]   bit_left_q, bit_left_d;
   logic [WORD_W-1:0]   buf_q, buf_d;
   logic                head_q, head_d;
   logic                en_q, en_d;
   logic                ready;

`ifdef CCFF_READBACK_EN
   logic [7:0] crc_sh_q, crc_sh_d;
   logic [7:0] crc_rb_q, crc_rb_d;
   logic       crc_err_q, crc_err_d;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction
`endif

   // Sequencer: next state, word buffer unload, handshake decode and shift counting
   always_comb begin
      state_d     = state_q;
      shift_cnt_d = shift_cnt_q;
      word_cnt_d  = word_cnt_q;
      bit_left_d  = bit_left_q;
      buf_d       = buf_q;
      head_d      = head_q;
      en_d        = 1'b0;
      ready       = 1'b0;
`ifdef CCFF_READBACK_EN
      crc_sh_d    = crc_sh_q;
      crc_rb_d    = crc_rb_q;
      crc_err_d   = crc_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_SHIFT;
               shift_cnt_d = '0;
               word_cnt_d  = '0;
               bit_left_d  = '0;
               buf_d       = '0;
               head_d      = 1'b0;
`ifdef CCFF_READBACK_EN
               crc_sh_d    = '0;
               crc_rb_d    = '0;
               crc_err_d   = 1'b0;
`endif
            end
         end
         S_SHIFT: begin
            ready = (bit_left_q == '0) && (word_cnt_q < WCNT_W'(NWORDS));
            if (en_q) begin
               shift_cnt_d = shift_cnt_q + 1'b1;
`ifdef CCFF_READBACK_EN
               crc_sh_d    = crc8_step(crc_sh_q, head_q);
`endif
            end
            if (en_q && (shift_cnt_q == CNT_W'(CHAIN_LEN - 1))) begin
               head_d = 1'b0;
`ifdef CCFF_READBACK_EN
               state_d     = S_VERIFY;
               shift_cnt_d = '0;
`else
               state_d     = S_DONE;
`endif
            end else if (bit_left_q != '0) begin
               head_d     = buf_q[WORD_W-1];
               buf_d      = buf_q << 1;
               bit_left_d = bit_left_q - 1'b1;
               en_d       = 1'b1;
            end else if (cfg.cfg_valid && ready) begin
               head_d     = cfg.cfg_data[WORD_W-1];
               buf_d      = cfg.cfg_data << 1;
               bit_left_d = (word_cnt_q == WCNT_W'(NWORDS - 1)) ? BCNT_W'(LAST_BITS - 1)
                                                                 : BCNT_W'(WORD_W - 1);
               word_cnt_d = word_cnt_q + 1'b1;
               en_d       = 1'b1;
            end
         end
`ifdef CCFF_READBACK_EN
         S_VERIFY: begin
            shift_cnt_d = shift_cnt_q + 1'b1;
            crc_rb_d    = crc8_step(crc_rb_q, ccff_tail);
            if (shift_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
               state_d   = S_DONE;
               crc_err_d = (crc8_step(crc_rb_q, ccff_tail) != crc_sh_q);
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q     <= S_IDLE;
         shift_cnt_q <= '0;
         word_cnt_q  <= '0;
         bit_left_q  <= '0;
         buf_q       <= '0;
         head_q      <= 1'b0;
         en_q        <= 1'b0;
`ifdef CCFF_READBACK_EN
         crc_sh_q    <= '0;
         crc_rb_q    <= '0;
         crc_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
         word_cnt_q  <= word_cnt_d;
         bit_left_q  <= bit_left_d;
         buf_q       <= buf_d;
         head_q      <= head_d;
         en_q        <= en_d;
`ifdef CCFF_READBACK_EN
         crc_sh_q    <= crc_sh_d;
         crc_rb_q    <= crc_rb_d;
         crc_err_q   <= crc_err_d;
`endif
      end
   end

   assign cfg.cfg_ready = ready;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);

`ifdef CCFF_READBACK_EN
   assign config_enable = en_q | (state_q == S_VERIFY);
   assign ccff_head     = (state_q == S_VERIFY) ? ccff_tail : head_q;
   assign crc_err       = crc_err_q;
`else
   logic unused_tail;
   assign unused_tail   = ccff_tail;
   assign config_enable = en_q;
   assign ccff_head     = head_q;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a shift-register model of the target chain.
module tb_ccff_loader;

   localparam int CHAIN_LEN = 52;
   localparam int WORD_W    = 8;
   localparam logic [CHAIN_LEN-1:0] IMAGE     = 52'hA53C0FF096695;
   localparam logic [CHAIN_LEN-1:0] FLIP_MASK = {{(CHAIN_LEN-18){1'b0}}, 1'b1, 17'b0};
`ifdef CCFF_READBACK_EN
   localparam int EXP_SHIFTS = 104;
`else
   localparam int EXP_SHIFTS = 52;
`endif

   logic prog_clk = 1'b0;
   logic pReset   = 1'b1;
   logic start    = 1'b0;
   logic ccff_head, config_enable, ccff_tail, busy, done;
`ifdef CCFF_READBACK_EN
   logic crc_err;
   logic done_crc = 1'b0;
`endif

   logic [WORD_W-1:0] words [7] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'h5E};

   int checks = 0;
   int errors = 0;

   logic [CHAIN_LEN-1:0] chain_model = '0;
   logic [CHAIN_LEN-1:0] cap         = '0;
   int   en_total    = 0;
   int   stall_total = 0;
   int   done_total  = 0;
   logic en_s        = 1'b0;
   logic head_s      = 1'b0;
   logic flip_arm    = 1'b0;
   int   flip_at     = 0;

   ccff_loader_if #(.WORD_W(WORD_W)) cfg_if ();

   ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .start         (start),
      .cfg           (cfg_if),
      .ccff_head     (ccff_head),
      .config_enable (config_enable),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done)
`ifdef CCFF_READBACK_EN
      ,
      .crc_err       (crc_err)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   assign ccff_tail = chain_model[CHAIN_LEN-1];

   // Sample DUT outputs mid-cycle and keep running stall/done tallies
   always @(negedge prog_clk) begin
      en_s   <= config_enable;
      head_s <= ccff_head;
      if (busy && !done && !config_enable) stall_total <= stall_total + 1;
      if (done) done_total <= done_total + 1;
   end

   // Chain model: shifts on each edge where config_enable was high
   always @(posedge prog_clk) begin
      if (en_s) begin
         chain_model <= {chain_model[CHAIN_LEN-2:0], head_s} ^
                        ((flip_arm && (en_total == flip_at)) ? FLIP_MASK : '0);
         cap         <= {cap[CHAIN_LEN-2:0], head_s};
         en_total    <= en_total + 1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: sim time expired before completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
   endtask

   task automatic send_words(input int drop_after, input int start_at);
      int   guard;
      int   n;
      logic acc;
      for (int i = 0; i < 7; i++) begin
         cfg_if.cfg_data  = words[i];
         cfg_if.cfg_valid = 1'b1;
         start = (i == start_at);
         guard = 0;
         acc   = 1'b0;
         while (!acc && guard < 100) begin
            @(negedge prog_clk);
            acc = cfg_if.cfg_ready;
            @(posedge prog_clk); #1;
            start = 1'b0;
            guard++;
         end
         cfg_if.cfg_valid = 1'b0;
         checks++;
         if (!acc) begin
            errors++;
            $display("[TB] FAIL word_accept[%0d]: accepted=0 required=1", i);
            return;
         end
         if (i == drop_after) begin
            n     = 0;
            guard = 0;
            while (n < 3 && guard < 100) begin
               @(negedge prog_clk);
               if (cfg_if.cfg_ready) n++;
               @(posedge prog_clk); #1;
               guard++;
            end
         end
      end
   endtask

   task automatic wait_done();
      int   guard;
      logic seen;
      guard = 0;
      seen  = 1'b0;
      while (!seen && guard < 300) begin
         @(negedge prog_clk);
         if (done) begin
            seen = 1'b1;
`ifdef CCFF_READBACK_EN
            done_crc = crc_err;
`endif
         end
         guard++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL done_timeout: done=0 required=1");
      end
      @(posedge prog_clk); #1;
      repeat (3) begin @(posedge prog_clk); #1; end
   endtask

   task automatic run_load(input int drop_after, input int start_at);
      do_start();
      send_words(drop_after, start_at);
      wait_done();
   endtask

   task automatic applyStimulusIdle();
      cfg_if.cfg_data  = '0;
      cfg_if.cfg_valid = 1'b0;
      start            = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulusIdle();
      pReset = 1'b1;
      repeat (2) @(posedge prog_clk);
      #1;
      @(negedge prog_clk);
      checks++; if (config_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable: got %b want 0", config_enable); end
      checks++; if (ccff_head !== 1'b0) begin errors++; $display("[TB] FAIL reset_head: got %b want 0", ccff_head); end
      checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", cfg_if.cfg_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
`ifdef CCFF_READBACK_EN
      checks++; if (crc_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_crc_err: got %b want 0", crc_err); end
`endif
      @(posedge prog_clk); #1;
      pReset = 1'b0;
      repeat (2) begin @(posedge prog_clk); #1; end
      checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready: got %b want 0", cfg_if.cfg_ready); end
   endtask

   task automatic test_back_to_back();
      int e0, s0, d0;
      e0 = en_total; s0 = stall_total; d0 = done_total;
      run_load(-1, -1);
      checks++; if (en_total - e0 != EXP_SHIFTS) begin errors++; $display("[TB] FAIL b2b_shifts: got %0d want %0d", en_total - e0, EXP_SHIFTS); end
      checks++; if (cap[CHAIN_LEN-1 -: 8] !== 8'hA5) begin errors++; $display("[TB] FAIL b2b_first_bits: got %h want a5", cap[CHAIN_LEN-1 -: 8]); end
      checks++; if (cap[3:0] !== 4'h5) begin errors++; $display("[TB] FAIL b2b_last_nibble: got %h want 5", cap[3:0]); end
      checks++; if (chain_model !== IMAGE) begin errors++; $display("[TB] FAIL b2b_image: got %h want %h", chain_model, IMAGE); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("[TB] FAIL b2b_done_pulses: got %0d want 1", done_total - d0); end
      checks++; if (stall_total - s0 != 1) begin errors++; $display("[TB] FAIL b2b_bubbles: got %0d want 1", stall_total - s0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_after: got %b want 0", busy); end
`ifdef CCFF_READBACK_EN
      checks++; if (done_crc !== 1'b0) begin errors++; $display("[TB] FAIL b2b_crc_err: got %b want 0", done_crc); end
`endif
   endtask

   task automatic test_stall();
      int e0, s0, d0;
      e0 = en_total; s0 = stall_total; d0 = done_total;
      run_load(1, -1);
      checks++; if (stall_total - s0 != 4) begin errors++; $display("[TB] FAIL stall_cycles: got %0d want 4", stall_total - s0); end
      checks++; if (en_total - e0 != EXP_SHIFTS) begin errors++; $display("[TB] FAIL stall_shifts: got %0d want %0d", en_total - e0, EXP_SHIFTS); end
      checks++; if (chain_model !== IMAGE) begin errors++; $display("[TB] FAIL stall_image: got %h want %h", chain_model, IMAGE); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("[TB] FAIL stall_done_pulses: got %0d want 1", done_total - d0); end
   endtask

   task automatic test_start_ignored();
      int e0, s0, d0;
      e0 = en_total; s0 = stall_total; d0 = done_total;
      run_load(-1, 3);
      checks++; if (en_total - e0 != EXP_SHIFTS) begin errors++; $display("[TB] FAIL restart_shifts: got %0d want %0d", en_total - e0, EXP_SHIFTS); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("[TB] FAIL restart_done_pulses: got %0d want 1", done_total - d0); end
      checks++; if (stall_total - s0 != 1) begin errors++; $display("[TB] FAIL restart_bubbles: got %0d want 1", stall_total - s0); end
      checks++; if (chain_model !== IMAGE) begin errors++; $display("[TB] FAIL restart_image: got %h want %h", chain_model, IMAGE); end
   endtask

   task automatic test_reset_mid();
      int e0, e1, d0, guard;
      e0 = en_total;
      do_start();
      cfg_if.cfg_data  = 8'hFF;
      cfg_if.cfg_valid = 1'b1;
      guard = 0;
      while ((en_total - e0) < 20 && guard < 200) begin
         @(posedge prog_clk); #1;
         guard++;
      end
      checks++; if ((en_total - e0) < 20) begin errors++; $display("[TB] FAIL midreset_reach20: got %0d want 20", en_total - e0); end
      pReset           = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      @(posedge prog_clk); #1;
      @(negedge prog_clk);
      checks++; if (config_enable !== 1'b0) begin errors++; $display("[TB] FAIL midreset_enable: got %b want 0", config_enable); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
      checks++; if (ccff_head !== 1'b0) begin errors++; $display("[TB] FAIL midreset_head: got %b want 0", ccff_head); end
      e1 = en_total;
      @(posedge prog_clk); #1;
      pReset = 1'b0;
      repeat (5) begin @(posedge prog_clk); #1; end
      checks++; if (en_total != e1) begin errors++; $display("[TB] FAIL midreset_no_shift: got %0d want %0d", en_total, e1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stays_idle: got %b want 0", busy); end
      e0 = en_total; d0 = done_total;
      run_load(-1, -1);
      checks++; if (en_total - e0 != EXP_SHIFTS) begin errors++; $display("[TB] FAIL reload_shifts: got %0d want %0d", en_total - e0, EXP_SHIFTS); end
      checks++; if (chain_model !== IMAGE) begin errors++; $display("[TB] FAIL reload_image: got %h want %h", chain_model, IMAGE); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("[TB] FAIL reload_done_pulses: got %0d want 1", done_total - d0); end
   endtask

`ifdef CCFF_READBACK_EN
   task automatic test_verify_flip();
      flip_at  = en_total + 60;
      flip_arm = 1'b1;
      run_load(-1, -1);
      flip_arm = 1'b0;
      checks++; if (done_crc !== 1'b1) begin errors++; $display("[TB] FAIL flip_crc_err_done: got %b want 1", done_crc); end
      checks++; if (crc_err !== 1'b1) begin errors++; $display("[TB] FAIL flip_crc_err_held: got %b want 1", crc_err); end
      do_start();
      @(negedge prog_clk);
      checks++; if (crc_err !== 1'b0) begin errors++; $display("[TB] FAIL flip_crc_err_cleared: got %b want 0", crc_err); end
      @(posedge prog_clk); #1;
      send_words(-1, -1);
      wait_done();
      checks++; if (done_crc !== 1'b0) begin errors++; $display("[TB] FAIL clean_crc_err: got %b want 0", done_crc); end
      checks++; if (chain_model !== IMAGE) begin errors++; $display("[TB] FAIL clean_image: got %h want %h", chain_model, IMAGE); end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_start_ignored();
      test_reset_mid();
`ifdef CCFF_READBACK_EN
      test_verify_flip();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
